// File: rtl/fifo_lane_dispatcher_pkg.sv
// Shared scheduler definitions: dispatcher state encoding, FIFO read latency
// and the lane-slice helper used by both the read- and write-side lane logic.
package fifo_lane_dispatcher_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StOffer = 2'd2
  } disp_state_t;

  // The scheduler FIFO returns read data exactly one cycle after a pop.
  localparam int unsigned FIFO_RD_LAT = 1;

  // Bit offset of lane `lane` inside a flat bus of `width`-bit lane slices.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fifo_lane_dispatcher_rr_lane_ptr.sv
// Modulo-N round-robin lane pointer; wraps N-1 -> 0 for any N >= 2.
module rr_lane_ptr #(
  parameter int unsigned N  = 4,
  parameter int unsigned LW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [LW-1:0] ptr
);

  localparam logic [LW-1:0] LastLane = LW'(N - 1);

  logic [LW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == LastLane) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_lane_dispatcher.sv
// Pops words from the scheduler FIFO and hands them one at a time to N lanes
// in strict round-robin order over per-lane valid/ready handshakes.
module fifo_lane_dispatcher
  import fifo_lane_dispatcher_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned LW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [WIDTH-1:0]   fifo_data_out,
  output logic [WIDTH*N-1:0] DIN_flat,
  output logic [N-1:0]       lane_valid,
  input  logic [N-1:0]       lane_ready,
  output logic [LW-1:0]      rr_ptr,
  output logic [CNT_W-1:0]   sent_count,
  output logic               busy
);

  disp_state_t      state_q;
  logic [WIDTH-1:0] hold_q;
  logic [CNT_W-1:0] count_q;
  logic             xfer;

  // Only the lane under the pointer can complete; other ready bits are ignored.
  assign xfer = (state_q == StOffer) && lane_ready[rr_ptr];

  rr_lane_ptr #(
    .N  (N),
    .LW (LW)
  ) u_rr_lane_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (xfer),
    .ptr     (rr_ptr)
  );

  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && !fifo_empty) begin
      unique case (state_q)
        StIdle:  fifo_rd_en = 1'b1;
        StOffer: fifo_rd_en = xfer;
        default: fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) state_q <= StFetch;
        end
        StFetch: begin
          hold_q  <= fifo_data_out;
          state_q <= StOffer;
        end
        StOffer: begin
          if (xfer) begin
            count_q <= count_q + 1'b1;
            state_q <= fifo_empty ? StIdle : StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Lane outputs depend only on registered state, so ready never loops back.
  always_comb begin
    lane_valid = '0;
    DIN_flat   = '0;
    for (int unsigned d = 0; d < N; d++) begin
      if (state_q == StOffer && rr_ptr == LW'(d)) begin
        lane_valid[d]                           = 1'b1;
        DIN_flat[lane_lsb(d, WIDTH) +: WIDTH]   = hold_q;
      end
    end
  end

  assign sent_count = count_q;
  assign busy       = (state_q != StIdle);

  a_no_pop_when_empty : assert property (@(posedge clk) !(fifo_rd_en && fifo_empty));
  a_valid_onehot0     : assert property (@(posedge clk) $onehot0(lane_valid));
  a_offer_held        : assert property (@(posedge clk) disable iff (rst)
      (state_q == StOffer && !xfer) |=> (state_q == StOffer && $stable(hold_q)
                                         && $stable(rr_ptr)));

endmodule

// File: tb/tb_fifo_lane_dispatcher.sv
// Bench for fifo_lane_dispatcher: a 4-lane instance (4-bit counter) and a 3-lane instance,
// each fed by a queue-based FIFO model and checked against an in-order word scoreboard.
module tb_fifo_lane_dispatcher;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        e4, rd4, b4;
  logic [7:0]  dout4;
  logic [31:0] din4;
  logic [3:0]  v4, r4, c4;
  logic [1:0]  p4;

  logic        e3, rd3, b3;
  logic [7:0]  dout3;
  logic [23:0] din3;
  logic [2:0]  v3, r3;
  logic [1:0]  p3;
  logic [15:0] c3;

  fifo_lane_dispatcher #(.WIDTH(8), .N(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(e4), .fifo_rd_en(rd4), .fifo_data_out(dout4),
    .DIN_flat(din4), .lane_valid(v4), .lane_ready(r4), .rr_ptr(p4), .sent_count(c4),
    .busy(b4)
  );

  fifo_lane_dispatcher #(.WIDTH(8), .N(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .fifo_empty(e3), .fifo_rd_en(rd3), .fifo_data_out(dout3),
    .DIN_flat(din3), .lane_valid(v3), .lane_ready(r3), .rr_ptr(p3), .sent_count(c3),
    .busy(b3)
  );

  int errors = 0;
  int checks = 0;

  // Model: FIFO contents, words owed to lanes in order, transfer counts.
  byte unsigned fq[2][$];
  byte unsigned exp_q[2][$];
  int           lanes[2][$];
  int           k[2];
  int           pops[2];
  logic [63:0]  pv[2], pd[2];
  logic         px[2];
  logic         s_rst;
  logic         s_rd[2];

  typedef struct {
    logic        rd;
    logic [3:0]  v;
    logic [31:0] din;
    logic [3:0]  cnt;
    logic [1:0]  ptr;
    logic        busy;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic score(input int id, input int n, input int unsigned cmask,
                       input logic [63:0] v, input logic [63:0] din, input logic [63:0] r,
                       input logic [63:0] ptr, input logic [63:0] cnt,
                       input logic busy, input logic rd, input logic empty);
    logic x;
    chk("rd_while_empty", 64'(rd & empty), 64'd0);
    chk("rr_ptr", ptr, 64'(k[id] % n));
    chk("sent_count", cnt, 64'(k[id] & cmask));
    if (v != 0) begin
      chk("lane_valid", v, 64'd1 << (k[id] % n));
      chk("busy_offer", 64'(busy), 64'd1);
      if (exp_q[id].size() == 0) chk("spurious_word", v, 64'd0);
      else chk("lane_data", din, 64'(exp_q[id][0]) << (8 * (k[id] % n)));
    end else begin
      chk("din_idle", din, 64'd0);
    end
    if (pv[id] != 0 && !px[id]) chk("offer_held", {v[31:0], din[31:0]},
                                    {pv[id][31:0], pd[id][31:0]});
    x = (v & r) != 0;
    if (x) begin
      if (exp_q[id].size() > 0) void'(exp_q[id].pop_front());
      lanes[id].push_back(k[id] % n);
      k[id]++;
    end
    pv[id] = v;
    pd[id] = din;
    px[id] = x;
  endtask

  task automatic at_negedge();
    @(negedge clk);
    s_rst   = rst;
    s_rd[0] = rd4;
    s_rd[1] = rd3;
    if (!rst) begin
      score(0, 4, 32'hf, 64'(v4), 64'(din4), 64'(r4), 64'(p4), 64'(c4), b4, rd4, e4);
      score(1, 3, 32'hffff, 64'(v3), 64'(din3), 64'(r3), 64'(p3), 64'(c3), b3, rd3, e3);
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    if (s_rst) begin
      for (int id = 0; id < 2; id++) begin
        fq[id].delete();
        exp_q[id].delete();
        k[id]  = 0;
        pv[id] = '0;
        px[id] = 1'b0;
      end
    end else begin
      if (s_rd[0] && fq[0].size() > 0) begin dout4 = fq[0].pop_front(); pops[0]++; end
      if (s_rd[1] && fq[1].size() > 0) begin dout3 = fq[1].pop_front(); pops[1]++; end
    end
    e4 = (fq[0].size() == 0);
    e3 = (fq[1].size() == 0);
  endtask

  task automatic cycle();
    at_negedge();
    finish_cycle();
  endtask

  task automatic push(input int id, input byte unsigned w);
    fq[id].push_back(w);
    exp_q[id].push_back(w);
    e4 = (fq[0].size() == 0);
    e3 = (fq[1].size() == 0);
  endtask

  task automatic run_until_k(input int id, input int target, input int budget);
    for (int i = 0; i < budget && k[id] != target; i++) cycle();
    if (k[id] != target) begin
      checks++;
      errors++;
      $display("FAIL timeout lane%0d: transfers %0d, expected %0d", id, k[id], target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dut4"}, {rd4, v4, din4, p4, c4, b4}, '0);
    chk({tag, "_dut3"}, {rd3, v3, din3, p3, c3, b3}, '0);
  endtask

  initial begin
    int unsigned pops_before;
    tbl[0] = '{1'b1, 4'h0, 32'h0,        4'd0, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 32'h0,        4'd0, 2'd0, 1'b1};
    tbl[2] = '{1'b1, 4'h1, 32'h11,       4'd0, 2'd0, 1'b1};
    tbl[3] = '{1'b0, 4'h0, 32'h0,        4'd1, 2'd1, 1'b1};
    tbl[4] = '{1'b1, 4'h2, 32'h2200,     4'd1, 2'd1, 1'b1};
    tbl[5] = '{1'b0, 4'h0, 32'h0,        4'd2, 2'd2, 1'b1};
    tbl[6] = '{1'b1, 4'h4, 32'h330000,   4'd2, 2'd2, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 32'h0,        4'd3, 2'd3, 1'b1};
    tbl[8] = '{1'b0, 4'h8, 32'h44000000, 4'd3, 2'd3, 1'b1};
    tbl[9] = '{1'b0, 4'h0, 32'h0,        4'd4, 2'd0, 1'b0};

    rst = 1'b1; e4 = 1'b1; e3 = 1'b1; dout4 = '0; dout3 = '0; r4 = '0; r3 = '0;
    for (int id = 0; id < 2; id++) begin
      k[id] = 0; pops[id] = 0; pv[id] = '0; pd[id] = '0; px[id] = 1'b0; s_rd[id] = 1'b0;
    end
    repeat (2) cycle();
    rst = 1'b0;
    at_negedge();
    check_reset_outputs("reset");
    finish_cycle();

    // Four words to four ready lanes, cycle-by-cycle against the table.
    r4 = 4'hf;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    for (int i = 0; i < 10; i++) begin
      at_negedge();
      chk($sformatf("t1_rd[%0d]", i), 64'(rd4), 64'(tbl[i].rd));
      chk($sformatf("t1_valid[%0d]", i), 64'(v4), 64'(tbl[i].v));
      chk($sformatf("t1_din[%0d]", i), 64'(din4), 64'(tbl[i].din));
      chk($sformatf("t1_cnt[%0d]", i), 64'(c4), 64'(tbl[i].cnt));
      chk($sformatf("t1_ptr[%0d]", i), 64'(p4), 64'(tbl[i].ptr));
      chk($sformatf("t1_busy[%0d]", i), 64'(b4), 64'(tbl[i].busy));
      finish_cycle();
    end

    // Move the pointer to lane 1, then stall lane 1 with 0xA5 on offer.
    push(0, 8'h01);
    run_until_k(0, 5, 20);
    r4 = 4'b1101;
    push(0, 8'hA5); push(0, 8'h77);
    repeat (2) cycle();
    pops_before = pops[0];
    for (int i = 0; i < 10; i++) begin
      at_negedge();
      chk("stall_valid", 64'(v4), 64'h2);
      chk("stall_din", 64'(din4), 64'hA500);
      chk("stall_rd", 64'(rd4), 64'd0);
      finish_cycle();
    end
    chk("stall_pops", 64'(pops[0]), 64'(pops_before));
    r4 = 4'hf;
    run_until_k(0, 7, 20);
    chk("stall_cnt", 64'(c4), 64'd7);

    // FIFO drained: idle with no pops, then resume on lane 3.
    for (int i = 0; i < 5; i++) begin
      at_negedge();
      chk("idle_busy", 64'(b4), 64'd0);
      chk("idle_rd", 64'(rd4), 64'd0);
      chk("idle_valid", 64'(v4), 64'd0);
      finish_cycle();
    end
    push(0, 8'h3C);
    repeat (2) cycle();
    at_negedge();
    chk("resume_valid", 64'(v4), 64'h8);
    chk("resume_din", 64'(din4), 64'h3C000000);
    finish_cycle();

    // Reset while the popped word is being fetched.
    cycle();
    push(0, 8'h5A);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    at_negedge();
    check_reset_outputs("rst_fetch");
    finish_cycle();
    for (int i = 0; i < 5; i++) begin
      at_negedge();
      chk("rst_no_ghost_valid", 64'(v4), 64'd0);
      chk("rst_no_ghost_din", 64'(din4), 64'd0);
      finish_cycle();
    end

    // Counter wrap on the 4-bit instance; 7 words through the 3-lane instance.
    lanes[1].delete();
    r3 = 3'b111;
    for (int i = 0; i < 7; i++) push(1, byte'(8'h61 + i));
    for (int i = 0; i < 15; i++) push(0, byte'($urandom));
    run_until_k(0, 15, 80);
    chk("wrap_cnt15", 64'(c4), 64'd15);
    chk("wrap_ptr15", 64'(p4), 64'd3);
    push(0, 8'hE1);
    run_until_k(0, 16, 20);
    cycle();
    at_negedge();
    chk("wrap_cnt0", 64'(c4), 64'd0);
    chk("wrap_ptr0", 64'(p4), 64'd0);
    chk("wrap_busy", 64'(b4), 64'd0);
    finish_cycle();
    chk("n3_count", 64'(lanes[1].size()), 64'd7);
    for (int i = 0; i < lanes[1].size(); i++) chk($sformatf("n3_lane[%0d]", i),
                                                   64'(lanes[1][i]), 64'(i % 3));
    chk("n3_ptr", 64'(p3), 64'd1);
    chk("n3_cnt", 64'(c3), 64'd7);

    // Random traffic, random readiness, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      r4  = 4'($urandom) | 4'($urandom);
      r3  = 3'($urandom) | 3'($urandom);
      if (!rst && $urandom_range(0, 2) == 0 && fq[0].size() < 6) push(0, byte'($urandom));
      if (!rst && $urandom_range(0, 2) == 0 && fq[1].size() < 6) push(1, byte'($urandom));
      cycle();
    end
    rst = 1'b0;
    r4  = 4'hf;
    r3  = 3'h7;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !b4 && !b3) break;
    end
    chk("drain_dut4_words", 64'(exp_q[0].size()), 64'd0);
    chk("drain_dut3_words", 64'(exp_q[1].size()), 64'd0);
    chk("drain_busy", {63'd0, b4 | b3}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_lane_dispatcher.md
# fifo_lane_dispatcher

Read-side counterpart of the global scheduler's lane-to-FIFO write path: pops words from the shared scheduler FIFO and delivers them, one word per transfer, to N PIM/PNM lanes in strict round-robin order. Each lane gets a valid/ready handshake. The block holds exactly one word in flight and never drops or duplicates data. It sits between the FIFO read port and the per-lane DIN inputs.

## Interface
- `WIDTH`, 8, data word width in bits.
- `N`, 4, number of lanes; must be ≥2. Lane index width is `LW = $clog2(N)`.
- `CNT_W`, 16, width of the dispatched-word counter.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `fifo_empty`  in  1  FIFO has no words.
- `fifo_rd_en`  out  1  FIFO pop request; data is returned exactly 1 cycle later.
- `fifo_data_out`  in  WIDTH  FIFO read data; valid in the cycle after `fifo_rd_en`.
- `DIN_flat`  out  WIDTH*N  per-lane data; lane d occupies bits `[WIDTH*(d+1)-1 : WIDTH*d]`.
- `lane_valid`  out  N  one-hot or zero; the selected lane has a word offered.
- `lane_ready`  in  N  the lane accepts the word this cycle.
- `rr_ptr`  out  LW  index of the lane that receives the next word.
- `sent_count`  out  CNT_W  number of completed transfers; wraps modulo 2^CNT_W.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, FETCH, OFFER.
- **IDLE**
  - `fifo_rd_en = !fifo_empty` (combinational).
  - If `!fifo_empty`, go to FETCH.
- **FETCH**
  - Capture `fifo_data_out` into hold register `hold_q`.
  - Go to OFFER.
  - `fifo_rd_en = 0`.
- **OFFER**
  - `lane_valid[rr_ptr] = 1`, all other bits 0.
  - `DIN` of lane `rr_ptr` = `hold_q`; all other lane DIN slices = 0.
  - Transfer occurs when `lane_ready[rr_ptr] & lane_valid[rr_ptr]`.
  - Ready bits of other lanes are ignored.
  - On a transfer:
    - `rr_ptr` advances by 1; it wraps from N-1 to 0, including for non-power-of-2 N.
    - `sent_count` increments.
    - If `!fifo_empty` in the same cycle, assert `fifo_rd_en` and go to FETCH (back-to-back). Otherwise go to IDLE.
  - No transfer: stay in OFFER. `hold_q`, `rr_ptr` and `lane_valid` are unchanged; valid is never withdrawn.
- Lane selection is strict: the block never skips a non-ready lane. A stalled lane stalls all lanes (ordering guarantee).
- `lane_valid` and `DIN` are decoded from registered state and `hold_q` only. They have no combinational path from `lane_ready`.
- `fifo_rd_en` is never asserted while `fifo_empty = 1`.
- Reset mid-operation:
  - Any held or fetched word is discarded.
  - FIFO data returning in the cycle after reset is ignored.
- Reset values:
  - state = IDLE, `fifo_rd_en` = 0, `lane_valid` = 0, `DIN_flat` = 0, `hold_q` = 0, `rr_ptr` = 0, `sent_count` = 0, `busy` = 0.

## Timing
- FIFO pop to lane offer: pop at cycle t (IDLE), capture at t+1 (FETCH), `lane_valid` high at t+2.
- Minimum transfer latency is 2 cycles from pop to offer.
- Sustained throughput with a non-empty FIFO and the target lane always ready: 1 word per 2 cycles (OFFER→FETCH→OFFER).
- `rr_ptr` and `sent_count` update on the edge that ends the transfer cycle. The next offer goes to the new lane.
- `fifo_empty` is sampled only in IDLE and in OFFER transfer cycles.

## Structure
- Shared scheduler package holds:
  - state enum `disp_state_t` {IDLE, FETCH, OFFER};
  - `FIFO_RD_LAT = 1`;
  - the lane-slice helper function (also used by the write-side selector).
- One natural sub-module: `rr_lane_ptr`, a modulo-N pointer with an advance input and sync reset. Inline it if that is simpler.

## Test plan
- Reset, then 4 words 0x11,0x22,0x33,0x44 in the FIFO with all `lane_ready = 1111`:
  - each lane d receives word d in order;
  - `fifo_rd_en` pulses every 2 cycles;
  - `sent_count = 4`;
  - `rr_ptr` returns to 0.
- Lane 1 ready held low for 10 cycles with 0xA5 offered to lane 1:
  - `lane_valid = 0010` and DIN1 = 0xA5 stable throughout;
  - no FIFO pops;
  - delivered when ready rises.
- N=3, 7 words: lane sequence is 0,1,2,0,1,2,0 and `rr_ptr` ends at 1.
- FIFO goes empty right after a transfer:
  - FSM returns to IDLE;
  - `busy = 0`;
  - no `fifo_rd_en` while empty;
  - resumes from the correct `rr_ptr` when a word arrives.
- Assert `rst` during FETCH:
  - next cycle all outputs are at reset values;
  - the returning FIFO data never appears on any lane.
- `sent_count` preloaded near wrap (CNT_W=4, 15 transfers, then 1 more): reads 0 with no other side effects.
